// File: rtl/dram_cim_channel_model.sv
// Behavioural DRAM compute-in-memory array: CH channels x 2**AW rows x DW bits.
// It supports WRITE, READ and in-array XOR, and returns each result bit-serially per channel after RD_LAT cycles.
module dram_cim_channel_model #(
  parameter int CH     = 16,
  parameter int DW     = 8,
  parameter int AW     = 4,
  parameter int RD_LAT = 2
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [CH*DW-1:0] cmd_wdata,
  output logic [CH-1:0]    rout,
  output logic             rout_vld,
  output logic             rout_last,
  output logic [CH*DW-1:0] rout_word,
  output logic             busy
);

  localparam int DEPTH = 1 << AW;
  localparam int BW    = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [3:0]    LAT_INIT = 4'(RD_LAT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DW - 1);
  localparam logic [BW-1:0] ONE_BIT  = BW'(1);
  localparam logic [BW-1:0] ZERO_BIT = BW'(0);

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_XOR   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  state_t              state_q;
  logic [3:0]          lat_q;
  logic [BW-1:0]       bit_q;
  logic [CH*DW-1:0]    res_q;
  logic [CH*DW-1:0]    mem_q [DEPTH];
  logic                ready_q;
  logic                busy_q;
  logic                vld_q;
  logic                last_q;
  logic [CH-1:0]       rout_q;
  logic [CH*DW-1:0]    word_q;

  logic                accept_s;
  logic                wr_en_s;
  logic [CH*DW-1:0]    row_s;
  logic [CH*DW-1:0]    res_d;
  logic [CH*DW-1:0]    wr_data_d;

  // Extracts bit k of every channel's stream, MSB first.
  function automatic logic [CH-1:0] bit_slice(input logic [CH*DW-1:0] w, input logic [BW-1:0] k);
    logic [CH-1:0] r;
    int            idx;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      idx  = c * DW + DW - 1 - int'(k);
      r[c] = w[idx];
    end
    return r;
  endfunction

  assign accept_s = cmd_valid & ready_q;
  assign wr_en_s  = accept_s & ((cmd_op == OP_WRITE) | (cmd_op == OP_XOR));

  // Result snapshot and write-back data; XOR reads and rewrites the row in the same cycle.
  always_comb begin
    row_s     = mem_q[cmd_addr];
    res_d     = row_s;
    wr_data_d = cmd_wdata;
    if (cmd_op == OP_XOR) begin
      res_d     = row_s ^ cmd_wdata;
      wr_data_d = row_s ^ cmd_wdata;
    end else begin
      res_d     = row_s;
      wr_data_d = cmd_wdata;
    end
  end

  // Array storage, cleared by reset.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_q[r] <= '0;
      end
    end else if (wr_en_s) begin
      mem_q[cmd_addr] <= wr_data_d;
    end
  end

  // Command FSM and serial result shifter; all outputs registered.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= S_IDLE;
      lat_q   <= 4'd0;
      bit_q   <= ZERO_BIT;
      res_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      rout_q  <= '0;
      word_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_s && cmd_op[1]) begin
            state_q <= S_WAIT;
            lat_q   <= LAT_INIT;
            res_q   <= res_d;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_WAIT: begin
          if (lat_q == 4'd0) begin
            state_q <= S_SHIFT;
            bit_q   <= ZERO_BIT;
            rout_q  <= bit_slice(res_q, ZERO_BIT);
            vld_q   <= 1'b1;
            last_q  <= (LAST_BIT == ZERO_BIT);
            word_q  <= res_q;
          end else begin
            lat_q <= lat_q - 4'd1;
          end
        end
        S_SHIFT: begin
          if (bit_q == LAST_BIT) begin
            state_q <= S_IDLE;
            bit_q   <= ZERO_BIT;
            rout_q  <= '0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            bit_q  <= bit_q + ONE_BIT;
            rout_q <= bit_slice(res_q, bit_q + ONE_BIT);
            last_q <= ((bit_q + ONE_BIT) == LAST_BIT);
          end
        end
        default: begin
          state_q <= S_IDLE;
          bit_q   <= ZERO_BIT;
          rout_q  <= '0;
          vld_q   <= 1'b0;
          last_q  <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign rout      = rout_q;
  assign rout_vld  = vld_q;
  assign rout_last = last_q;
  assign rout_word = word_q;

endmodule

// File: tb/tb_dram_cim_channel_model.sv
// Bench for dram_cim_channel_model: a cycle-indexed model checks the default instance every cycle.
// A small CH=2/DW=4/RD_LAT=1 instance is checked against a hand-computed table.
module tb_dram_cim_channel_model;
  localparam int CH = 16, DW = 8, AW = 4, L = 2, W = CH * DW;
  localparam logic [1:0] NOP = 2'b00, WR = 2'b01, RD = 2'b10, XR = 2'b11;

  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;

  logic          cmd_valid = 1'b0, cmd_ready;
  logic [1:0]    cmd_op = NOP;
  logic [AW-1:0] cmd_addr = '0;
  logic [W-1:0]  cmd_wdata = '0;
  logic [CH-1:0] rout;
  logic          rout_vld, rout_last, busy;
  logic [W-1:0]  rout_word;

  logic       s_valid = 1'b0, s_ready;
  logic [1:0] s_op = NOP;
  logic [3:0] s_addr = 4'd0;
  logic [7:0] s_wdata = 8'd0;
  logic [1:0] s_rout;
  logic       s_vld, s_last, s_busy;
  logic [7:0] s_word;

  dram_cim_channel_model #(.CH(CH), .DW(DW), .AW(AW), .RD_LAT(L)) dut (
    .CLK(CLK), .RSTn(RSTn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rout(rout), .rout_vld(rout_vld),
    .rout_last(rout_last), .rout_word(rout_word), .busy(busy));

  dram_cim_channel_model #(.CH(2), .DW(4), .AW(4), .RD_LAT(1)) dut_s (
    .CLK(CLK), .RSTn(RSTn), .cmd_valid(s_valid), .cmd_ready(s_ready), .cmd_op(s_op),
    .cmd_addr(s_addr), .cmd_wdata(s_wdata), .rout(s_rout), .rout_vld(s_vld),
    .rout_last(s_last), .rout_word(s_word), .busy(s_busy));

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: array contents, the transaction in flight (accept edge, result) and the word on display.
  logic [W-1:0] m_mem [16];
  logic [W-1:0] m_res = '0, m_shown = '0;
  int  edge_n = 0, m_T = -1000, m_acc_e = -1;
  bit  m_active = 1'b0;

  function automatic bit m_ready_after(input int e);
    return !m_active || (e >= m_T + L + DW);
  endfunction

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int r = 0; r < 16; r++) m_mem[r] = '0;
      m_active = 1'b0;
      m_res    = '0;
      m_shown  = '0;
    end else begin
      edge_n++;
      if (cmd_valid && m_ready_after(edge_n - 1)) begin
        m_acc_e = edge_n;
        case (cmd_op)
          WR: m_mem[cmd_addr] = cmd_wdata;
          RD: begin m_res = m_mem[cmd_addr]; m_active = 1'b1; m_T = edge_n; end
          XR: begin
            m_res = m_mem[cmd_addr] ^ cmd_wdata;
            m_mem[cmd_addr] = m_res;
            m_active = 1'b1;
            m_T = edge_n;
          end
          default: ;
        endcase
      end
      if (m_active && edge_n >= m_T + L) m_shown = m_res;
    end
  end

  // Per-cycle comparison of the default instance against the model, away from the rising edge.
  bit            chk_on = 1'b0, prev_vld = 1'b0;
  int            ce, ck, first_e = -1;
  logic          e_vld, e_last, e_ready;
  logic [CH-1:0] e_rout;
  logic [7:0]    cap0 = 8'd0, cap15 = 8'd0;

  always @(negedge CLK) begin
    if (chk_on) begin
      ce     = edge_n;
      ck     = ce - m_T - L;
      e_vld  = m_active && ck >= 0 && ck < DW;
      e_rout = '0;
      if (e_vld) for (int c = 0; c < CH; c++) e_rout[c] = m_res[c*DW + DW - 1 - ck];
      e_last  = e_vld && ck == DW - 1;
      e_ready = m_ready_after(ce);
      chk("rout_vld", rout_vld, e_vld);
      chk("rout", rout, e_rout);
      chk("rout_last", rout_last, e_last);
      chk("cmd_ready", cmd_ready, e_ready);
      chk("busy", busy, !e_ready);
      chk("rout_word", rout_word, m_shown);
      if (rout_vld) begin
        cap0  = {cap0[6:0], rout[0]};
        cap15 = {cap15[6:0], rout[15]};
        if (!prev_vld) first_e = ce;
      end
      prev_vld = rout_vld;
    end
  end

  task automatic send(input logic [1:0] op, input logic [3:0] a, input logic [W-1:0] d);
    int n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = d;
    do begin
      @(posedge CLK); #1; n++;
    end while (m_acc_e != edge_n && n < 40);
    if (m_acc_e != edge_n) begin
      checks++; failures++;
      $display("FAIL send_timeout: op %0d not accepted within %0d cycles", op, n);
    end
    cmd_valid = 1'b0; cmd_op = NOP; cmd_wdata = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  localparam logic [W-1:0] A5S  = {16{8'hA5}};
  localparam logic [W-1:0] ONES = {16{8'hFF}};
  localparam logic [W-1:0] T2D  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [W-1:0] T2K  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [W-1:0] T2R  = 128'h00102030405060708090a0b0c0d0e0f0;

  // Hand-computed stream for the small instance: row 2 = 8'h9C (ch0 = 4'hC, ch1 = 4'h9).
  logic       tv_vld  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [1:0] tv_rout [5] = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b00};
  logic       tv_last [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic       tv_rdy  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  int t;

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_vld", rout_vld, 1'b0);
    chk("rst_word", rout_word, '0);
    chk_on = 1'b1;
    RSTn = 1'b1;
    idle(1);

    // 1: write/read A5 pattern
    send(WR, 4'd0, A5S);
    send(RD, 4'd0, '0);
    t = edge_n;
    idle(12);
    chk("t1_first_vld_lat", W'(first_e - t), W'(2));
    chk("t1_stream_ch0", cap0, 8'hA5);
    chk("t1_stream_ch15", cap15, 8'hA5);
    chk("t1_word", rout_word, A5S);

    // 2: XOR (AddRoundKey) with write-back
    send(WR, 4'd3, T2D);
    send(XR, 4'd3, T2K);
    idle(12);
    chk("t2_xor_word", rout_word, T2R);
    send(RD, 4'd3, '0);
    idle(12);
    chk("t2_readback_word", rout_word, T2R);
    chk("t2_stream_ch0", cap0, 8'hF0);
    chk("t2_stream_ch15", cap15, 8'h00);

    // 4: write held valid throughout a busy read
    send(RD, 4'd0, '0);
    send(WR, 4'd1, ONES);
    send(RD, 4'd1, '0);
    idle(12);
    chk("t4_word", rout_word, ONES);

    // 5: reset during the 4th bit of a stream
    send(RD, 4'd0, '0);
    repeat (5) @(posedge CLK);
    #2 RSTn = 1'b0;
    #1;
    chk("t5_vld", rout_vld, 1'b0);
    chk("t5_rout", rout, '0);
    chk("t5_word", rout_word, '0);
    chk("t5_ready", cmd_ready, 1'b1);
    repeat (2) @(posedge CLK);
    #1 RSTn = 1'b1;
    send(RD, 4'd1, '0);
    idle(12);
    chk("t5_read_after_rst", rout_word, '0);

    // 3: top address does not alias
    send(WR, 4'd15, ONES);
    send(RD, 4'd0, '0);
    idle(12);
    chk("t3_row0_zero", rout_word, '0);
    send(RD, 4'd7, '0);
    idle(12);
    chk("t3_row7_zero", rout_word, '0);
    send(RD, 4'd15, '0);
    idle(12);
    chk("t3_row15_ones", rout_word, ONES);
    chk("t3_stream_ch0", cap0, 8'hFF);

    // 6: small instance, RD_LAT=1
    s_valid = 1'b1; s_op = WR; s_addr = 4'd2; s_wdata = 8'h9C;
    @(posedge CLK); #1;
    chk("t6_ready_after_write", s_ready, 1'b1);
    s_op = RD;
    @(posedge CLK); #1;
    s_valid = 1'b0; s_op = NOP; s_wdata = 8'd0;
    chk("t6_ready_at_accept", s_ready, 1'b0);
    chk("t6_vld_at_accept", s_vld, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(posedge CLK); #1;
      chk("t6_vld", s_vld, tv_vld[k]);
      chk("t6_rout", s_rout, tv_rout[k]);
      chk("t6_last", s_last, tv_last[k]);
      chk("t6_ready", s_ready, tv_rdy[k]);
      chk("t6_busy", s_busy, !tv_rdy[k]);
      chk("t6_word", s_word, 8'h9C);
    end

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
